// File: rtl/fp32_divider.sv
`default_nettype none
// ============================================================================
// Module      : fp32_divider
// Description : IEEE-754 single-precision divider (a / b), restoring mantissa
//               divider with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_divider #(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_invalid,
    output logic        flag_div_by_zero,
    output logic        flag_overflow,
    output logic        flag_underflow
);

    localparam int         C_STEPS    = 26 / UNROLL;
    localparam logic [4:0] C_CNT_LAST = 5'(C_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_sign;
    logic [7:0]  r_ea;
    logic [7:0]  r_eb;
    logic [23:0] r_mb;
    logic [24:0] r_rem;
    logic [25:0] r_q;
    logic [4:0]  r_cnt;

    // ------------------------------------------------------------------
    // Operand classification, evaluated on the live inputs at accept
    // ------------------------------------------------------------------
    logic        w_a_zero, w_a_inf, w_a_nan;
    logic        w_b_zero, w_b_inf, w_b_nan;
    logic        w_sign;
    logic        w_spec_invalid, w_spec_inf, w_spec_zero, w_special;
    logic        w_spec_dbz;
    logic [31:0] w_spec_result;

    always_comb begin
        w_a_zero = (a[30:23] == 8'h00);
        w_b_zero = (b[30:23] == 8'h00);
        w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        w_sign   = a[31] ^ b[31];

        w_spec_invalid = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
        w_spec_inf     = w_a_inf || w_b_zero;
        w_spec_zero    = w_a_zero || w_b_inf;
        w_special      = w_spec_invalid || w_spec_inf || w_spec_zero;
        // inf / 0 is an exact infinity, not a division-by-zero event
        w_spec_dbz     = !w_spec_invalid && w_b_zero && !w_a_inf;

        if (w_spec_invalid) begin
            w_spec_result = {w_sign, 8'hFF, 23'h400000};
        end else if (w_spec_inf) begin
            w_spec_result = {w_sign, 8'hFF, 23'h000000};
        end else begin
            w_spec_result = {w_sign, 31'h0};
        end
    end

    // ------------------------------------------------------------------
    // Restoring division: UNROLL quotient bits per cycle, MSB first
    // ------------------------------------------------------------------
    logic [24:0] w_rem_nx;
    logic [25:0] w_q_nx;

    always_comb begin
        w_rem_nx = r_rem;
        w_q_nx   = r_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (w_rem_nx >= {1'b0, r_mb}) begin
                w_rem_nx = (w_rem_nx - {1'b0, r_mb}) << 1;
                w_q_nx   = {w_q_nx[24:0], 1'b1};
            end else begin
                w_rem_nx = w_rem_nx << 1;
                w_q_nx   = {w_q_nx[24:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Normalise, round to nearest even, range check
    // ------------------------------------------------------------------
    logic               w_rem_nz;
    logic signed [9:0]  w_exp_diff;
    logic signed [9:0]  w_exp_norm;
    logic signed [9:0]  w_exp_rnd;
    logic [22:0]        w_mant;
    logic [22:0]        w_mant_rnd;
    logic [23:0]        w_mant_sum;
    logic               w_guard, w_sticky, w_round_up;
    logic               w_ovf, w_unf;
    logic [31:0]        w_norm_result;

    always_comb begin
        w_rem_nz   = |r_rem;
        w_exp_diff = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb});

        if (r_q[25]) begin
            w_mant     = r_q[24:2];
            w_guard    = r_q[1];
            w_sticky   = r_q[0] | w_rem_nz;
            w_exp_norm = w_exp_diff + 10'sd127;
        end else begin
            w_mant     = r_q[23:1];
            w_guard    = r_q[0];
            w_sticky   = w_rem_nz;
            w_exp_norm = w_exp_diff + 10'sd126;
        end

        w_round_up = w_guard & (w_sticky | w_mant[0]);
        w_mant_sum = {1'b0, w_mant} + {23'h0, w_round_up};

        // Carry out of the fraction means the value became exactly 2.0 * 2^e
        if (w_mant_sum[23]) begin
            w_mant_rnd = 23'h0;
            w_exp_rnd  = w_exp_norm + 10'sd1;
        end else begin
            w_mant_rnd = w_mant_sum[22:0];
            w_exp_rnd  = w_exp_norm;
        end

        w_ovf = (w_exp_rnd >= 10'sd255);
        w_unf = (w_exp_rnd <= 10'sd0);

        if (w_ovf) begin
            w_norm_result = {r_sign, 8'hFF, 23'h0};
        end else if (w_unf) begin
            w_norm_result = {r_sign, 31'h0};
        end else begin
            w_norm_result = {r_sign, w_exp_rnd[7:0], w_mant_rnd};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_sign           <= 1'b0;
            r_ea             <= 8'h0;
            r_eb             <= 8'h0;
            r_mb             <= 24'h0;
            r_rem            <= 25'h0;
            r_q              <= 26'h0;
            r_cnt            <= 5'h0;
            out_valid        <= 1'b0;
            result           <= 32'h0;
            flag_invalid     <= 1'b0;
            flag_div_by_zero <= 1'b0;
            flag_overflow    <= 1'b0;
            flag_underflow   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_sign;
                        r_ea   <= a[30:23];
                        r_eb   <= b[30:23];
                        r_mb   <= {1'b1, b[22:0]};
                        r_rem  <= {2'b01, a[22:0]};
                        r_q    <= 26'h0;
                        r_cnt  <= C_CNT_LAST;
                        if (w_special) begin
                            result           <= w_spec_result;
                            flag_invalid     <= w_spec_invalid;
                            flag_div_by_zero <= w_spec_dbz;
                            flag_overflow    <= 1'b0;
                            flag_underflow   <= 1'b0;
                            out_valid        <= 1'b1;
                            r_state          <= S_DONE;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_q   <= w_q_nx;
                    if (r_cnt == 5'h0) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_cnt <= r_cnt - 5'h1;
                    end
                end
                S_ROUND: begin
                    result           <= w_norm_result;
                    flag_invalid     <= 1'b0;
                    flag_div_by_zero <= 1'b0;
                    flag_overflow    <= w_ovf;
                    flag_underflow   <= w_unf;
                    out_valid        <= 1'b1;
                    r_state          <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fp32_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_divider
// Description : Directed self-checking bench for fp32_divider, UNROLL 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_divider;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INV  = 4'b1000;
    localparam logic [3:0] F_DBZ  = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;

    logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1;
    logic        inv_1, dbz_1, ovf_1, unf_1;
    logic [31:0] result_1;
    logic        in_valid_2, in_ready_2, out_valid_2, out_ready_2;
    logic        inv_2, dbz_2, ovf_2, unf_2;
    logic [31:0] result_2;

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic [31:0] obs_result;
    logic [3:0]  obs_flags;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign in_valid_1  = in_valid & ~sel;
    assign in_valid_2  = in_valid & sel;
    assign out_ready_1 = out_ready & ~sel;
    assign out_ready_2 = out_ready & sel;

    fp32_divider #(.UNROLL(1)) u_dut1 (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid_1),
        .in_ready         (in_ready_1),
        .a                (a),
        .b                (b),
        .out_valid        (out_valid_1),
        .out_ready        (out_ready_1),
        .result           (result_1),
        .flag_invalid     (inv_1),
        .flag_div_by_zero (dbz_1),
        .flag_overflow    (ovf_1),
        .flag_underflow   (unf_1)
    );

    fp32_divider #(.UNROLL(2)) u_dut2 (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid_2),
        .in_ready         (in_ready_2),
        .a                (a),
        .b                (b),
        .out_valid        (out_valid_2),
        .out_ready        (out_ready_2),
        .result           (result_2),
        .flag_invalid     (inv_2),
        .flag_div_by_zero (dbz_2),
        .flag_overflow    (ovf_2),
        .flag_underflow   (unf_2)
    );

    assign obs_in_ready  = sel ? in_ready_2  : in_ready_1;
    assign obs_out_valid = sel ? out_valid_2 : out_valid_1;
    assign obs_result    = sel ? result_2    : result_1;
    assign obs_flags     = sel ? {inv_2, dbz_2, ovf_2, unf_2} : {inv_1, dbz_1, ovf_1, unf_1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at #1 after a clock edge; leaves the bench at #1 after the handshake edge
    task automatic do_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags,
                         input int exp_lat, input int hold);
        int lat;
        int ready_hi;
        check({tag, " in_ready before accept"}, 32'(obs_in_ready), 32'd1);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        lat      = -1;
        ready_hi = obs_in_ready ? 1 : 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (obs_out_valid) begin
                lat = i;
                break;
            end
            if (obs_in_ready) ready_hi++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " in_ready while busy"}, 32'(ready_hi), 32'd0);
        check({tag, " result"}, obs_result, exp_res);
        check({tag, " flags"}, 32'(obs_flags), 32'(exp_flags));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " held out_valid"}, 32'(obs_out_valid), 32'd1);
            check({tag, " held result"}, obs_result, exp_res);
            check({tag, " held flags"}, 32'(obs_flags), 32'(exp_flags));
            check({tag, " held in_ready"}, 32'(obs_in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 32'(obs_out_valid), 32'd0);
        check({tag, " in_ready after handshake"}, 32'(obs_in_ready), 32'd1);
    endtask

    task automatic reset_abort(input string tag);
        int seen;
        a        = 32'h40C0_0000;
        b        = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check({tag, " out_valid"}, 32'(obs_out_valid), 32'd0);
        check({tag, " result"}, obs_result, 32'h0);
        check({tag, " flags"}, 32'(obs_flags), 32'(F_NONE));
        check({tag, " in_ready"}, 32'(obs_in_ready), 32'd1);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (obs_out_valid) seen++;
        end
        check({tag, " no output after abort"}, 32'(seen), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out_valid", 32'(obs_out_valid), 32'd0);
        check("reset result", obs_result, 32'h0);
        check("reset flags", 32'(obs_flags), 32'(F_NONE));
        check("reset in_ready", 32'(obs_in_ready), 32'd1);

        // UNROLL = 1
        do_op("u1 6/2",       32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 27, 0);
        do_op("u1 1/3",       32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, F_NONE, 27, 0);
        do_op("u1 -2/0.5",    32'hC000_0000, 32'h3F00_0000, 32'hC080_0000, F_NONE, 27, 0);
        do_op("u1 1/0",       32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, F_DBZ,  1,  0);
        do_op("u1 0/0",       32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, F_INV,  1,  0);
        do_op("u1 inf/-inf",  32'h7F80_0000, 32'hFF80_0000, 32'hFFC0_0000, F_INV,  1,  0);
        do_op("u1 0/inf",     32'h0000_0000, 32'h7F80_0000, 32'h0000_0000, F_NONE, 1,  0);
        do_op("u1 nan/-1",    32'h7F80_0001, 32'hBF80_0000, 32'hFFC0_0000, F_INV,  1,  0);
        do_op("u1 subn/1",    32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, F_NONE, 1,  0);
        do_op("u1 overflow",  32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, F_OVF,  27, 0);
        do_op("u1 underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, F_UNF,  27, 0);
        do_op("u1 backpress", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, F_NONE, 27, 5);
        do_op("u1 b2b",       32'hC000_0000, 32'h3F00_0000, 32'hC080_0000, F_NONE, 27, 0);
        reset_abort("u1 abort");
        do_op("u1 6/2 after abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 27, 0);

        // UNROLL = 2
        sel = 1'b1;
        #0;
        do_op("u2 6/2",       32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 14, 0);
        do_op("u2 1/3",       32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, F_NONE, 14, 5);
        do_op("u2 1/0",       32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, F_DBZ,  1,  0);
        do_op("u2 underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, F_UNF,  14, 0);
        reset_abort("u2 abort");
        do_op("u2 6/2 after abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 14, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
